// File: rtl/fiber_link_monitor_if.sv
// Frame-decoder to link-monitor handshake: one strobe per received frame plus its CRC verdict.
interface fiber_link_monitor_if;
    logic frame_done;
    logic frame_crc_ok;

    modport master (output frame_done, output frame_crc_ok);
    modport slave  (input  frame_done, input  frame_crc_ok);
endinterface

// File: rtl/fiber_link_monitor.sv
// Downlink fiber supervisor: frame-gap timeout and consecutive-CRC-failure faults,
// link status and a saturating bad-frame counter.
module fiber_link_monitor #(
    parameter int STARTUP_US  = 5000,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       time_1us,
    input  logic                       reset_unit,
    fiber_link_monitor_if.slave        frm,
    input  logic [13:0]                timeout_us,
    input  logic [3:0]                 verify_limit,
    output logic                       link_up,
    output logic                       Fiber_delay_err,
    output logic                       Fiber_verify_err,
    output logic [15:0]                bad_frame_cnt
);

    typedef enum logic [1:0] {S_INIT, S_UP, S_FAULT} state_t;

    localparam logic [13:0] STARTUP_LIM = 14'(STARTUP_US);
    localparam logic [3:0]  LOCK_LIM    = 4'(LOCK_FRAMES);

    state_t      state;
    logic [1:0]  time_1us_syn;
    logic [13:0] gap_cnt;
    logic [3:0]  bad_run;
    logic [3:0]  good_run;

    logic tick;
    logic good_frame;
    logic bad_frame;
    logic lock_hit;
    logic startup_hit;
    logic delay_hit;
    logic verify_hit;

    // All decisions look at the registered counters, i.e. the values before this frame/tick.
    assign tick        = (time_1us_syn == 2'b01);
    assign good_frame  = frm.frame_done &&  frm.frame_crc_ok;
    assign bad_frame   = frm.frame_done && !frm.frame_crc_ok;
    assign lock_hit    = good_frame && (({1'b0, good_run} + 5'd1) >= {1'b0, LOCK_LIM});
    assign startup_hit = !frm.frame_done && (gap_cnt >= STARTUP_LIM);
    assign delay_hit   = (timeout_us != 14'd0) && (gap_cnt >= timeout_us) && !frm.frame_done;
    assign verify_hit  = (verify_limit != 4'd0) && bad_frame &&
                         (({1'b0, bad_run} + 5'd1) >= {1'b0, verify_limit});

    // NOTE: every register here uses non-blocking assignment so all branches read pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || reset_unit) begin
            state            <= S_INIT;
            time_1us_syn     <= 2'b00;
            gap_cnt          <= '0;
            bad_run          <= '0;
            good_run         <= '0;
            link_up          <= 1'b0;
            Fiber_delay_err  <= 1'b0;
            Fiber_verify_err <= 1'b0;
            // A unit fault-reset keeps the lifetime bad-frame statistic.
            if (rst) begin
                bad_frame_cnt <= '0;
            end
        end else begin
            time_1us_syn <= {time_1us_syn[0], time_1us};

            if (frm.frame_done) begin
                gap_cnt <= '0;
            end else if (tick && gap_cnt != 14'h3FFF) begin
                gap_cnt <= gap_cnt + 14'd1;
            end

            if (good_frame) begin
                bad_run <= '0;
                if (good_run != 4'hF) good_run <= good_run + 4'd1;
            end else if (bad_frame) begin
                good_run <= '0;
                if (bad_run != 4'hF) bad_run <= bad_run + 4'd1;
            end

            if (bad_frame && bad_frame_cnt != 16'hFFFF) begin
                bad_frame_cnt <= bad_frame_cnt + 16'd1;
            end

            case (state)
                S_INIT: begin
                    if (lock_hit) begin
                        state   <= S_UP;
                        link_up <= 1'b1;
                    end else if (startup_hit) begin
                        state           <= S_FAULT;
                        Fiber_delay_err <= 1'b1;
                    end
                end
                S_UP: begin
                    if (delay_hit || verify_hit) begin
                        state            <= S_FAULT;
                        link_up          <= 1'b0;
                        Fiber_delay_err  <= delay_hit;
                        Fiber_verify_err <= verify_hit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fiber_link_monitor.sv
// Self-checking bench for fiber_link_monitor: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the link rules.
module tb_fiber_link_monitor;

    localparam int STARTUP_US  = 5000;
    localparam int LOCK_FRAMES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        time_1us;
    logic        reset_unit;
    logic [13:0] timeout_us;
    logic [3:0]  verify_limit;
    logic        link_up;
    logic        Fiber_delay_err;
    logic        Fiber_verify_err;
    logic [15:0] bad_frame_cnt;

    fiber_link_monitor_if frm_if ();

    fiber_link_monitor #(.STARTUP_US(STARTUP_US), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .clk              (clk),
        .rst              (rst),
        .time_1us         (time_1us),
        .reset_unit       (reset_unit),
        .frm              (frm_if),
        .timeout_us       (timeout_us),
        .verify_limit     (verify_limit),
        .link_up          (link_up),
        .Fiber_delay_err  (Fiber_delay_err),
        .Fiber_verify_err (Fiber_verify_err),
        .bad_frame_cnt    (bad_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: microsecond gap, run lengths and a locked/faulted pair of flags.
    int last_in[$];
    int m_gap, m_bad_run, m_good_run, m_bad_cnt;
    bit m_up, m_fault, m_derr, m_verr;

    wire [18:0] dut_out = {link_up, Fiber_delay_err, Fiber_verify_err, bad_frame_cnt};

    function automatic logic [18:0] exp_out();
        logic [15:0] cnt;
        cnt = 16'(m_bad_cnt);
        return {m_up, m_derr, m_verr, cnt};
    endfunction

    task automatic model_clock(input logic t, input logic fd, input logic ok,
                               input logic ru, input logic r);
        bit us_tick, good, bad, d, v;
        if (r || ru) begin
            last_in = '{0, 0};
            m_gap = 0; m_bad_run = 0; m_good_run = 0;
            m_up = 0; m_fault = 0; m_derr = 0; m_verr = 0;
            if (r) m_bad_cnt = 0;
            return;
        end
        // A microsecond is seen once the synchronised input was low two samples ago and high one ago.
        us_tick = (last_in[0] == 0) && (last_in[1] == 1);
        good = fd && ok;
        bad  = fd && !ok;
        if (!m_up && !m_fault) begin
            if (good && m_good_run + 1 >= LOCK_FRAMES) m_up = 1;
            else if (!fd && m_gap >= STARTUP_US) begin
                m_fault = 1; m_derr = 1;
            end
        end else if (m_up) begin
            d = (timeout_us != 0) && (m_gap >= int'(timeout_us)) && !fd;
            v = (verify_limit != 0) && bad && (m_bad_run + 1 >= int'(verify_limit));
            if (d || v) begin
                m_up = 0; m_fault = 1; m_derr = d; m_verr = v;
            end
        end
        if (fd) m_gap = 0;
        else if (us_tick) m_gap = (m_gap + 1 > 16383) ? 16383 : m_gap + 1;
        if (good) begin
            m_bad_run = 0;
            m_good_run = (m_good_run + 1 > 15) ? 15 : m_good_run + 1;
        end
        if (bad) begin
            m_good_run = 0;
            m_bad_run = (m_bad_run + 1 > 15) ? 15 : m_bad_run + 1;
            m_bad_cnt = (m_bad_cnt + 1 > 65535) ? 65535 : m_bad_cnt + 1;
        end
        void'(last_in.pop_front());
        last_in.push_back(int'(t));
    endtask

    // One clock: drive inputs, let DUT and model take the edge, return at the following negedge.
    task automatic step(input logic t, input logic fd, input logic ok,
                        input logic ru, input logic r);
        time_1us            = t;
        frm_if.frame_done   = fd;
        frm_if.frame_crc_ok = ok;
        reset_unit          = ru;
        rst                 = r;
        @(posedge clk);
        model_clock(t, fd, ok, ru, r);
        @(negedge clk);
    endtask

    task automatic idle_us(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic frame_us(input logic ok);
        step(1'b1, 1'b1, ok, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_rst();
        n_cmp++;
        if (dut_out !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", dut_out, 19'd0);
        end
        for (int i = 0; i < STARTUP_US; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i % 500 == 0 || i == STARTUP_US - 1) begin
                n_cmp++;
                if (dut_out !== exp_out()) begin
                    n_bad++;
                    $display("FAIL startup_wait us=%0d: got %h expected %h", i, dut_out, exp_out());
                end
            end
        end
        n_cmp++;
        if (Fiber_delay_err !== 1'b0) begin
            n_bad++;
            $display("FAIL startup_early: delay_err got %b expected 0", Fiber_delay_err);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_out !== {1'b0, 1'b1, 1'b0, 16'd0} || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL startup_timeout: got %h expected %h", dut_out, exp_out());
        end
    endtask

    task automatic test_lock();
        timeout_us = 14'd0; verify_limit = 4'd0;
        do_rst();
        for (int k = 0; k < 3; k++) begin
            idle_us(49); frame_us(1'b1);
        end
        idle_us(49);
        n_cmp++;
        if (link_up !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_before_4th: link_up got %b expected 0", link_up);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (link_up !== 1'b1 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL lock_after_4th: got %h expected %h", dut_out, exp_out());
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_rst();
        for (int k = 0; k < 3; k++) begin
            idle_us(49); frame_us(1'b1);
        end
        idle_us(49); frame_us(1'b0);
        for (int k = 0; k < 3; k++) begin
            idle_us(49); frame_us(1'b1);
        end
        n_cmp++;
        if (link_up !== 1'b0 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL lock_restart_3: got %h expected %h", dut_out, exp_out());
        end
        idle_us(49); frame_us(1'b1);
        n_cmp++;
        if (link_up !== 1'b1 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL lock_restart_4: got %h expected %h", dut_out, exp_out());
        end
    endtask

    task automatic test_gap();
        bit seen;
        bit t;
        timeout_us = 14'd100;
        seen = 0; t = 1'b1;
        for (int i = 0; i < 600 && !seen; i++) begin
            step(t, 1'b0, 1'b0, 1'b0, 1'b0);
            t = ~t;
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_bad++;
                $display("FAIL gap_timeout cyc=%0d: got %h expected %h", i, dut_out, exp_out());
            end
            seen = m_fault;
        end
        n_cmp++;
        if (Fiber_delay_err !== 1'b1 || link_up !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_fault_raised: delay_err got %b link_up got %b expected 1/0",
                     Fiber_delay_err, link_up);
        end

        // Second pass: a frame lands exactly on the cycle the gap threshold is reached.
        timeout_us = 14'd0;
        do_rst();
        repeat (LOCK_FRAMES) frame_us(1'b1);
        timeout_us = 14'd100;
        t = 1'b1;
        for (int i = 0; i < 600 && m_gap < 100; i++) begin
            step(t, 1'b0, 1'b0, 1'b0, 1'b0);
            t = ~t;
        end
        step(t, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (Fiber_delay_err !== 1'b0 || link_up !== 1'b1 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL gap_frame_same_cycle: got %h expected %h", dut_out, exp_out());
        end
        idle_us(20);
        n_cmp++;
        if (dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL gap_after_rescue: got %h expected %h", dut_out, exp_out());
        end
    endtask

    task automatic test_crc();
        logic seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        timeout_us = 14'd0; verify_limit = 4'd3;
        do_rst();
        repeat (LOCK_FRAMES) begin
            idle_us(49); frame_us(1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            idle_us(49);
            step(1'b1, 1'b1, seq[k], 1'b0, 1'b0);
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_bad++;
                $display("FAIL crc_frame%0d: got %h expected %h", k + 1, dut_out, exp_out());
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (dut_out !== {1'b0, 1'b0, 1'b1, 16'd5}) begin
            n_bad++;
            $display("FAIL crc_verify_fault: got %h expected %h", dut_out, {1'b0, 1'b0, 1'b1, 16'd5});
        end
    endtask

    task automatic test_clear();
        frame_us(1'b0);
        n_cmp++;
        if (dut_out !== {1'b0, 1'b0, 1'b1, 16'd6}) begin
            n_bad++;
            $display("FAIL clear_fault_counts: got %h expected %h", dut_out, {1'b0, 1'b0, 1'b1, 16'd6});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_out !== {1'b0, 1'b0, 1'b0, 16'd6} || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL clear_reset_unit: got %h expected %h", dut_out, exp_out());
        end
        repeat (3) frame_us(1'b1);
        n_cmp++;
        if (link_up !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_back_in_init: link_up got %b expected 0", link_up);
        end
        frame_us(1'b1);
        n_cmp++;
        if (link_up !== 1'b1 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL clear_relock: got %h expected %h", dut_out, exp_out());
        end
        do_rst();
        n_cmp++;
        if (dut_out !== 19'd0) begin
            n_bad++;
            $display("FAIL clear_rst_count: got %h expected %h", dut_out, 19'd0);
        end
    endtask

    task automatic test_disables();
        timeout_us = 14'd0; verify_limit = 4'd0;
        do_rst();
        repeat (LOCK_FRAMES) frame_us(1'b1);
        for (int k = 0; k < 20; k++) begin
            idle_us(1000);
            n_cmp++;
            if (dut_out !== exp_out() || link_up !== 1'b1) begin
                n_bad++;
                $display("FAIL dis_long_gap ms=%0d: got %h expected %h", k, dut_out, exp_out());
            end
        end
        // A saturated gap still reads 16383, so re-enabling at that limit faults at once.
        timeout_us = 14'h3FFF;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (Fiber_delay_err !== 1'b1 || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL dis_gap_saturation: got %h expected %h", dut_out, exp_out());
        end

        timeout_us = 14'd0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (LOCK_FRAMES) frame_us(1'b1);
        repeat (20) frame_us(1'b0);
        n_cmp++;
        if (dut_out !== {1'b1, 1'b0, 1'b0, 16'd20}) begin
            n_bad++;
            $display("FAIL dis_20_bad: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b0, 16'd20});
        end
        verify_limit = 4'd15;
        frame_us(1'b0);
        n_cmp++;
        if (dut_out !== {1'b0, 1'b0, 1'b1, 16'd21} || dut_out !== exp_out()) begin
            n_bad++;
            $display("FAIL dis_bad_run_saturation: got %h expected %h", dut_out, exp_out());
        end
    endtask

    task automatic test_random();
        logic t, fd, ok, ru, r;
        do_rst();
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) begin
                timeout_us   = 14'($urandom_range(0, 40));
                verify_limit = 4'($urandom_range(0, 4));
            end
            t  = 1'($urandom_range(0, 1));
            fd = ($urandom_range(0, 3) == 0);
            ok = ($urandom_range(0, 3) != 0);
            ru = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(t, fd, ok, ru, r);
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_bad++;
                $display("FAIL random cyc=%0d: got %h expected %h", i, dut_out, exp_out());
            end
        end
    endtask

    initial begin
        last_in = '{0, 0};
        m_gap = 0; m_bad_run = 0; m_good_run = 0; m_bad_cnt = 0;
        m_up = 0; m_fault = 0; m_derr = 0; m_verr = 0;
        rst = 1'b1; time_1us = 1'b0; reset_unit = 1'b0;
        frm_if.frame_done = 1'b0; frm_if.frame_crc_ok = 1'b0;
        timeout_us = 14'd0; verify_limit = 4'd0;
        @(negedge clk);
        test_reset();
        test_lock();
        test_gap();
        test_crc();
        test_clear();
        test_disables();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
